// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream -> big-endian 32-bit words at addresses 0..N-1.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              core_enable_o,
  output logic [ADDR_W:0]   word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_COLLECT, S_WRITE, S_DONE, S_ERROR, S_CHECK
  } state_e;

  localparam logic [8:0]      DEPTH_W = 9'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       shift_q;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   word_count_q;
  logic              byte_ready_q, wr_en_q, busy_q, done_q, error_q, core_enable_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              fire;
  logic              hdr_bad;
  logic [31:0]       shift_d;
  logic [ADDR_W:0]   wcnt_d;

  assign fire    = byte_valid_i & byte_ready_q;
  assign hdr_bad = (byte_data_i == 8'd0) || ({1'b0, byte_data_i} > DEPTH_W);
  assign shift_d = {shift_q[23:0], byte_data_i};
  assign wcnt_d  = word_count_q + ONE_W;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      byte_idx_q    <= '0;
      shift_q       <= '0;
      n_q           <= '0;
      word_count_q  <= '0;
      byte_ready_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      core_enable_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_q       <= S_HEADER;
            byte_ready_q  <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            core_enable_q <= 1'b0;
            word_count_q  <= '0;
            byte_idx_q    <= '0;
            shift_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
          end
        end
        S_HEADER: begin
          if (fire) begin
            if (hdr_bad) begin
              state_q      <= S_ERROR;
              error_q      <= 1'b1;
              busy_q       <= 1'b0;
              byte_ready_q <= 1'b0;
            end else begin
              n_q     <= byte_data_i[ADDR_W:0];
              state_q <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (fire) begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ byte_data_i;
`endif
            if (byte_idx_q == 2'd3) begin
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              wr_en_q      <= 1'b1;
              wr_addr_q    <= word_count_q[ADDR_W-1:0];
              wr_data_q    <= shift_d;
            end
          end
        end
        S_WRITE: begin
          word_count_q <= wcnt_d;
          byte_idx_q   <= '0;
          if (wcnt_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q       <= S_CHECK;
            byte_ready_q  <= 1'b1;
`else
            state_q       <= S_DONE;
            done_q        <= 1'b1;
            core_enable_q <= 1'b1;
            busy_q        <= 1'b0;
`endif
          end else begin
            state_q      <= S_COLLECT;
            byte_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (fire) begin
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            if (byte_data_i == csum_q) begin
              state_q       <= S_DONE;
              done_q        <= 1'b1;
              core_enable_q <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready_o  = byte_ready_q;
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign core_enable_o = core_enable_q;
  assign word_count_o  = word_count_q;

endmodule
